bitwise_logic_pipe: RTL and testbench
=====================================

Name: bitwise_logic_pipe

Overview:
Parametrised successor to the team's fixed 8-bit AND unit. Takes two WIDTH-bit operands and computes one of eight selectable bitwise operations. The result passes through an elastic STAGES-deep pipeline with valid/ready handshakes on both sides. An optional accumulate mode replaces operand b with a running result register. Instantiated inside the tt_um top wrapper, which drives it from ui_in/uio_in/uo_out.

Parameters:
WIDTH, 8, operand and result width in bits (1..32)
STAGES, 2, number of pipeline register stages (1..4); unloaded latency in cycles

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; 0 freezes all state
in_valid  input  1  upstream presents a valid operand pair
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand a
b  input  WIDTH  operand b (ignored when acc_mode=1)
op  input  3  operation select, sampled with the operands
acc_mode  input  1  1: use accumulator in place of b
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  y holds a valid result
out_ready  input  1  downstream accepts this cycle
y  output  WIDTH  result

Behaviour:
- Reset, asynchronous on rst_n low: all stage valid bits=0, stage data=0, accumulator=0. Outputs: out_valid=0, y=0, in_ready=1.
- Op encoding on b_eff:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 ANDN (a & ~b_eff)
  - 7 PASS_A (y=a)
- b_eff = acc_mode ? acc : b.
- The function is evaluated combinationally at accept time. Stage 1 captures the result, not the operands.
- Accept occurs when in_valid & in_ready & ena.
- Output handshake completes when out_valid & out_ready & ena.
- Elastic pipeline:
  - Stage k loads from stage k-1 when (stage k empty or stage k is advancing) and ena=1.
  - The last stage advances when out_ready=1.
  - in_ready = ena & (stage 1 empty or stage 1 advancing).
  - in_ready is derived combinationally from out_ready; a full pipeline with out_ready=1 sustains one transfer per cycle.
- Latency: exactly STAGES cycles from accept to out_valid when unstalled.
- Order is preserved. No result is dropped or duplicated under any out_ready pattern.
- Backpressure: when out_ready=0 and all stages are valid, in_ready=0 and y/out_valid hold stable.
- y = last-stage data. It is driven even when out_valid=0, holding the last value, and is 0 after reset.
- Accumulator:
  - On accept with acc_mode=1, acc <= computed result.
  - With acc_mode=0, acc is unchanged.
  - acc_clr=1 (with ena) sets acc=0 next cycle. acc_clr takes priority over an update in the same cycle.
  - An accept in the acc_clr cycle uses the pre-clear acc value as b_eff.
- ena=0: no accept, no advance, no acc change. in_ready=0. out_valid holds its value, but no handshake completes.
- rst_n low mid-operation flushes all in-flight results immediately. The first accept after release produces normal results.

Optional Feature:
Macro BITWISE_LOGIC_PIPE_FLAGS_EN.
- Defined:
  - Adds output flags[1:0]: bit0 = zero (result==0), bit1 = odd parity (XOR of result bits).
  - Flags are computed at accept and travel in the pipeline alongside the data, so they are aligned with y.
  - Reset value 2'b01, matching y=0.
- Not defined: the port is absent and no flag registers are generated.

Test Plan:
- Reset then single op, WIDTH=8, STAGES=2, out_ready=1: accept a=0xF0, b=0x3C, op=0 (AND) -> out_valid high exactly 2 cycles later with y=0x30. Before that accept, y=0 and out_valid=0.
- All ops back-to-back, a=0xA5, b=0x0F, in_valid=1 for 8 cycles, op=0..7 -> y sequence is 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0xA0, 0xA5 on 8 consecutive cycles.
- Backpressure: stream 6 XOR results while out_ready toggles randomly -> every result appears once, in order. in_ready=0 only when both stages are full and out_ready=0. y is stable while out_valid & !out_ready.
- Accumulate: acc_clr pulse, then acc_mode=1, op=1 (OR), a=0x01, 0x02, 0x04 -> y = 0x01, 0x03, 0x07. Then acc_clr with a simultaneous accept of a=0x80 -> y=0x87, and the next accept of a=0x10 gives y=0x10.
- ena/reset: with 2 results in flight, drop ena for 3 cycles -> no state change and in_ready=0. Then assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and y=0 immediately. No stale result appears after release.
- Flags (macro defined): XOR a=0x5A, b=0x5A -> y=0x00, flags=2'b01. OR a=0x07, b=0x00 -> y=0x07, flags=2'b10.

Source files
------------

// File: rtl/bitwise_logic_pipe.sv
// Bitwise logic unit: eight selectable ops on two WIDTH-bit operands. The result
// travels through an elastic STAGES-deep valid/ready pipeline. An optional
// accumulate mode swaps operand b for a running result register.
// Optional feature: define BITWISE_LOGIC_PIPE_FLAGS_EN to add a flags[1:0]
// output (bit0 = zero, bit1 = odd parity) that travels aligned with y.
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    ,
    output logic [1:0]       flags
`endif
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  result;
    logic [STAGES-1:0] load;
    logic              accept;

    // Operation select, evaluated at accept time on the effective b operand
    always_comb begin
        b_eff  = acc_mode ? acc_q : b;
        result = a;
        case (op)
            3'd0:    result = a & b_eff;
            3'd1:    result = a | b_eff;
            3'd2:    result = a ^ b_eff;
            3'd3:    result = ~(a & b_eff);
            3'd4:    result = ~(a | b_eff);
            3'd5:    result = ~(a ^ b_eff);
            3'd6:    result = a & ~b_eff;
            default: result = a;
        endcase
    end

    // Stage k may load if some stage at or after k is empty, or the tail drains;
    // this closed form avoids a ripple chain through the advance signals.
    always_comb begin
        logic full;
        load = '0;
        full = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & valid_q[j];
            end
            load[k] = ena & (~full | out_ready);
        end
    end

    assign in_ready  = load[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];

    // Pipeline registers; data only moves with a valid token so y holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= result;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    // Accumulator: clear wins over an update in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (ena && acc_clr) begin
            acc_q <= '0;
        end else if (accept && acc_mode) begin
            acc_q <= result;
        end
    end

`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    logic [1:0] flag_q [STAGES];
    logic [1:0] result_flags;

    assign result_flags = {^result, (result == '0)};
    assign flags        = flag_q[STAGES-1];

    // Flag registers shadow the data registers so flags stay aligned with y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                flag_q[k] <= 2'b01;
            end
        end else begin
            if (load[0] && in_valid) begin
                flag_q[0] <= result_flags;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    flag_q[k] <= flag_q[k-1];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe (WIDTH=8, STAGES=2): random traffic
// checked against a queue-based model, plus directed literal scenarios.
module tb_bitwise_logic_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    logic [1:0]       flags;
`endif

    int total = 0;
    int bad   = 0;

    bitwise_logic_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .acc_mode (acc_mode),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference semantics of the eight ops
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return x & ~z;
            default: return x;
        endcase
    endfunction

    // Model state: results in flight, accumulator, observed outputs
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] acc_m  = '0;
    logic             hold_p = 1'b0;
    logic [WIDTH-1:0] y_p    = '0;
    logic             exp_rdy;
    logic [WIDTH-1:0] r;

    // Compare process: samples 2 time units after each falling edge
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            acc_m  = '0;
            hold_p = 1'b0;
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_y", 32'(y), 32'd0);
        end else begin
            exp_rdy = ena && ((exp_q.size() < STAGES) || out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (hold_p) begin
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_y", 32'(y), 32'(y_p));
            end
            if (exp_q.size() == 0) begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
            end
            if (out_valid && out_ready && ena && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("y", 32'(y), 32'(r));
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
                chk("flags", 32'(flags), 32'({^r, (r == '0)}));
`endif
                got_q.push_back(y);
            end
            if (in_valid && exp_rdy) begin
                r = ref_op(op, a, acc_mode ? acc_m : b);
                exp_q.push_back(r);
                if (!acc_clr && acc_mode) begin
                    acc_m = r;
                end
            end
            if (ena && acc_clr) begin
                acc_m = '0;
            end
            hold_p = out_valid && !(out_ready && ena);
            y_p    = y;
        end
    end

    task automatic drive(input logic iv, input logic [2:0] o, input logic [WIDTH-1:0] aa,
                         input logic [WIDTH-1:0] bb, input logic am, input logic ac,
                         input logic ordy, input logic en);
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        a         = aa;
        b         = bb;
        acc_mode  = am;
        acc_clr   = ac;
        out_ready = ordy;
        ena       = en;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic drain_check(input string name);
        idle(STAGES + 4);
        chk({name, "_drained_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_model_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [WIDTH-1:0] ops_exp[8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'hA5};
    logic [WIDTH-1:0] acc_exp[5] = '{8'h01, 8'h03, 8'h07, 8'h87, 8'h10};
    logic [WIDTH-1:0] acc_in[5]  = '{8'h01, 8'h02, 8'h04, 8'h80, 8'h10};

    initial begin
        int cnt;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_mode  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        // Reset then a single AND
        idle(2);
        rst_n = 1'b1;
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_y", 32'(y), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
        chk("post_reset_flags", 32'(flags), 32'h1);
`endif
        drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("single_pre_valid", 32'(out_valid), 32'd0);
        chk("single_pre_y", 32'(y), 32'd0);
        idle(1);
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        idle(1);
        chk("single_lat2_valid", 32'(out_valid), 32'd1);
        chk("single_y", 32'(y), 32'h30);

        // All eight ops back-to-back
        for (int s = 0; s < 10; s++) begin
            drive(s < 8, 3'(s), 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
            if (s >= 2) begin
                chk("ops_valid", 32'(out_valid), 32'd1);
                chk("ops_y", 32'(y), 32'(ops_exp[s-2]));
            end
        end
        drain_check("ops");

        // Six XOR results under random backpressure
        cnt = 0;
        for (int s = 0; s < 60 && cnt < 6; s++) begin
            drive(1'b1, 3'd2, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b1);
            if (in_ready) cnt++;
        end
        chk("bp_accepted", 32'(cnt), 32'd6);
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 3'd2, '0, '0, 1'b0, 1'b0, 1'($urandom), 1'b1);
        end
        drain_check("bp");

        // Fully random traffic
        for (int s = 0; s < 400; s++) begin
            drive(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                  1'($urandom), $urandom_range(0, 9) != 0);
        end
        drain_check("rand");

        // Accumulate with OR, clear coinciding with an accept
        got_q.delete();
        drive(1'b0, 3'd1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, acc_in[i], 8'hFF, 1'b1, i == 3, 1'b1, 1'b1);
        end
        drain_check("acc");
        chk("acc_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            chk("acc_y", 32'(got_q[i]), 32'(acc_exp[i]));
        end

        // ena freeze with two results in flight, then asynchronous reset
        got_q.delete();
        drive(1'b1, 3'd0, 8'hFF, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'd1, 8'h20, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("ena_in_ready", 32'(in_ready), 32'd0);
            chk("ena_out_valid", 32'(out_valid), 32'd1);
            chk("ena_y", 32'(y), 32'h11);
        end
        @(negedge clk);
        ena      = 1'b1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_y", 32'(y), 32'd0);
        idle(1);
        rst_n = 1'b1;
        drive(1'b1, 3'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        drain_check("rst");
        chk("rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            chk("rst_first_y", 32'(got_q[0]), 32'h3C);
        end

`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
        // Flag literals
        drive(1'b1, 3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'd1, 8'h07, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("flag_zero_y", 32'(y), 32'h00);
        chk("flag_zero", 32'(flags), 32'h1);
        idle(1);
        chk("flag_par_y", 32'(y), 32'h07);
        chk("flag_par", 32'(flags), 32'h2);
        drain_check("flags");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
